// File: rtl/tnoc_pkg.sv
// Shared types for the flit-mux arbiter family: arbiter FSM states,
// default statistics counter width and a pointer-width helper.
package tnoc_pkg;

    localparam int TNOC_DEFAULT_COUNT_WIDTH = 16;

    typedef enum logic {
        TNOC_ARB_IDLE = 1'b0,
        TNOC_ARB_BUSY = 1'b1
    } tnoc_arb_state_e;

    // A single-entry arbiter still carries a 1-bit pointer so ports never collapse to zero width.
    function automatic int tnoc_ptr_width(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/tnoc_round_robin_arbiter.sv
// Combinational round-robin pick: first requester at or after i_pointer,
// wrapping, returned as a one-hot grant plus the pointer to use next time.
module tnoc_round_robin_arbiter
    import tnoc_pkg::*;
#(
    parameter int ENTRIES = 2,
    parameter int PTR_W   = tnoc_ptr_width(ENTRIES)
) (
    input  logic [ENTRIES-1:0] i_request,
    input  logic [PTR_W-1:0]   i_pointer,
    output logic [ENTRIES-1:0] o_grant,
    output logic [PTR_W-1:0]   o_next_pointer
);

    logic [2*ENTRIES-1:0] req_dbl;
    logic [2*ENTRIES-1:0] grant_dbl;
    logic [ENTRIES-1:0]   req_rot;
    logic [ENTRIES-1:0]   grant_rot;
    logic                 found;

    // Rotate so the pointer entry sits at bit 0, pick the lowest set bit, rotate back.
    assign req_dbl = {i_request, i_request} >> i_pointer;
    assign req_rot = req_dbl[ENTRIES-1:0];

    always_comb begin
        grant_rot = '0;
        found     = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!found && req_rot[i]) begin
                grant_rot[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign grant_dbl = {grant_rot, grant_rot} << i_pointer;
    assign o_grant   = grant_dbl[2*ENTRIES-1:ENTRIES];

    always_comb begin
        o_next_pointer = i_pointer;
        for (int j = 0; j < ENTRIES; j++) begin
            if (o_grant[j]) begin
                o_next_pointer = (j == ENTRIES - 1) ? '0 : PTR_W'(j + 1);
            end
        end
    end

endmodule

// File: rtl/tnoc_flit_mux_arbiter.sv
// Packet-level round-robin arbiter driving the one-hot flit-mux select.
// Define TNOC_FLIT_MUX_ARBITER_STATS_EN to add saturating per-entry grant counters.
module tnoc_flit_mux_arbiter
    import tnoc_pkg::*;
#(
    parameter int ENTRIES     = 2,
    parameter int COUNT_WIDTH = TNOC_DEFAULT_COUNT_WIDTH
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [ENTRIES-1:0]             i_request,
    input  logic                           i_free,
    output logic [ENTRIES-1:0]             o_grant,
    output logic                           o_busy
`ifdef TNOC_FLIT_MUX_ARBITER_STATS_EN
    ,
    output logic [ENTRIES*COUNT_WIDTH-1:0] o_grant_count
`endif
);

    localparam int PTR_W = tnoc_ptr_width(ENTRIES);

    tnoc_arb_state_e    state_q, state_d;
    logic [ENTRIES-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [ENTRIES-1:0] arb_grant;
    logic [PTR_W-1:0]   arb_next_ptr;
    logic               new_grant;

    tnoc_round_robin_arbiter #(
        .ENTRIES (ENTRIES),
        .PTR_W   (PTR_W)
    ) u_rr (
        .i_request      (i_request),
        .i_pointer      (ptr_q),
        .o_grant        (arb_grant),
        .o_next_pointer (arb_next_ptr)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= TNOC_ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Arbitration happens only from IDLE or on the tail-accept cycle, so a
    // packet in flight can never lose or change its grant.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        new_grant = 1'b0;
        if (state_q == TNOC_ARB_IDLE || i_free) begin
            if (|i_request) begin
                state_d   = TNOC_ARB_BUSY;
                grant_d   = arb_grant;
                ptr_d     = arb_next_ptr;
                new_grant = 1'b1;
            end else begin
                state_d = TNOC_ARB_IDLE;
                grant_d = '0;
            end
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q == TNOC_ARB_BUSY);

`ifdef TNOC_FLIT_MUX_ARBITER_STATS_EN
    logic [COUNT_WIDTH-1:0] count_q [ENTRIES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) count_q[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (new_grant && grant_d[i] && (count_q[i] != '1)) begin
                    count_q[i] <= count_q[i] + COUNT_WIDTH'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_count_out
        assign o_grant_count[g*COUNT_WIDTH +: COUNT_WIDTH] = count_q[g];
    end
`else
    // Without statistics COUNT_WIDTH only takes part in this parameter sanity guard.
    if (ENTRIES < 1 || COUNT_WIDTH < 1) begin : g_bad_params
    end
`endif

endmodule

// File: tb/tb_tnoc_flit_mux_arbiter.sv
// Scoreboard bench for tnoc_flit_mux_arbiter (ENTRIES=4): directed vectors push
// expected {busy, grant}; a monitor pops and compares one entry per cycle.
module tb_tnoc_flit_mux_arbiter;

    localparam int N  = 4;
    localparam int CW = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] request = '0;
    logic         free = 1'b0;
    logic [N-1:0] grant;
    logic         busy;
`ifdef TNOC_FLIT_MUX_ARBITER_STATS_EN
    logic [N*CW-1:0] grant_count;
`endif

    int         checks = 0;
    int         errors = 0;
    int         step = 0;
    logic [4:0] exp_q [$];
    logic [4:0] exp_v;

    tnoc_flit_mux_arbiter #(
        .ENTRIES     (N),
        .COUNT_WIDTH (CW)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_request (request),
        .i_free    (free),
        .o_grant   (grant),
        .o_busy    (busy)
`ifdef TNOC_FLIT_MUX_ARBITER_STATS_EN
        ,
        .o_grant_count (grant_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; expectation is the {busy, grant} seen after the next edge.
    task automatic drive(input logic [N-1:0] req, input logic fr,
                         input logic exp_busy, input logic [N-1:0] exp_grant);
        @(negedge clk);
        request = req;
        free    = fr;
        exp_q.push_back({exp_busy, exp_grant});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        request = '0;
        free    = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check($sformatf("cycle_%0d busy_grant", step), {27'd0, busy, grant}, {27'd0, exp_v});
            step++;
        end
    end

    initial begin
        #12;
        check("reset grant", {28'd0, grant}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from IDLE, then release with nothing pending.
        drive(4'b0100, 1'b0, 1'b1, 4'b0100);
        drive(4'b0000, 1'b1, 1'b0, 4'b0000);
        drive(4'b0000, 1'b0, 1'b0, 4'b0000);

        // All requesting, tail every cycle: rotation with no bubbles.
        apply_reset();
        drive(4'b1111, 1'b0, 1'b1, 4'b0001);
        drive(4'b1111, 1'b1, 1'b1, 4'b0010);
        drive(4'b1111, 1'b1, 1'b1, 4'b0100);
        drive(4'b1111, 1'b1, 1'b1, 4'b1000);
        drive(4'b1111, 1'b1, 1'b1, 4'b0001);
        drive(4'b0000, 1'b1, 1'b0, 4'b0000);

        // Five-flit packet on entry 1; request dropped and entry 3 raised mid-packet.
        drive(4'b0010, 1'b0, 1'b1, 4'b0010);
        drive(4'b0010, 1'b0, 1'b1, 4'b0010);
        drive(4'b0000, 1'b0, 1'b1, 4'b0010);
        drive(4'b1000, 1'b0, 1'b1, 4'b0010);
        drive(4'b1000, 1'b0, 1'b1, 4'b0010);
        drive(4'b1000, 1'b1, 1'b1, 4'b1000);
        // Same entry requests again at release: back-to-back regrant.
        drive(4'b1000, 1'b1, 1'b1, 4'b1000);
        drive(4'b0000, 1'b1, 1'b0, 4'b0000);

        // Free while IDLE is ignored; pointer still 0 so 1111 grants entry 0.
        drive(4'b0000, 1'b1, 1'b0, 4'b0000);
        drive(4'b0000, 1'b1, 1'b0, 4'b0000);
        drive(4'b1111, 1'b0, 1'b1, 4'b0001);
        drive(4'b0000, 1'b1, 1'b0, 4'b0000);

        // Pointer at 1: search wraps past 3 back to 0.
        drive(4'b1001, 1'b0, 1'b1, 4'b1000);
        drive(4'b1001, 1'b1, 1'b1, 4'b0001);
        drive(4'b0000, 1'b1, 1'b0, 4'b0000);

        // Asynchronous reset in the middle of a packet on entry 2.
        drive(4'b0100, 1'b0, 1'b1, 4'b0100);
        drive(4'b0100, 1'b0, 1'b1, 4'b0100);
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        request = '0;
        #1;
        check("async reset grant", {28'd0, grant}, 32'd0);
        check("async reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1111, 1'b0, 1'b1, 4'b0001);
        drive(4'b0000, 1'b1, 1'b0, 4'b0000);

`ifdef TNOC_FLIT_MUX_ARBITER_STATS_EN
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            drive(4'b0001, 1'b0, 1'b1, 4'b0001);
            drive(4'b0000, 1'b1, 1'b0, 4'b0000);
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            check($sformatf("grant_count_%0d", i),
                  {30'd0, grant_count[i*CW +: CW]}, (i == 0) ? 32'd3 : 32'd0);
        end
`endif

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        check("queue drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tnoc_flit_mux_arbiter.md
Name: tnoc_flit_mux_arbiter

Overview:
- Packet-level round-robin arbiter that drives the one-hot select of the flit-interface mux.
- Shares one flit output among ENTRIES requesters.
- A grant is held from head-flit acceptance until tail-flit acceptance, so a packet is never interleaved with another.
- Sits beside the mux in router output stages and local-port adapters.

Parameters:
- ENTRIES, 2, number of requesters; must be >= 1.
- COUNT_WIDTH, 16, width of each per-entry grant counter (optional feature only).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_request  input  ENTRIES  bit i: entry i presents a head flit (valid on any channel).
- i_free  input  1  tail flit of the granted entry was accepted at the mux output (valid & ready & tail).
- o_grant  output  ENTRIES  one-hot grant, or all-zero; connects directly to the mux select.
- o_busy  output  1  a grant is held.
- o_grant_count  output  ENTRIES*COUNT_WIDTH  per-entry packet-grant counters (optional feature only).

Clock/reset: one clock; reset is asynchronous and active-low.

Behaviour:
- States: IDLE (o_grant=0, o_busy=0) and BUSY (o_grant one-hot, o_busy=1). State, grant and pointer are all registered.
- Reset values: state=IDLE, o_grant=0, o_busy=0, priority pointer=entry 0, counters=0.
- IDLE -> BUSY: when i_request != 0, pick the first requesting entry at or after the pointer, wrapping ENTRIES-1 -> 0.
  - o_grant is asserted the following cycle (latency 1 cycle from request to grant).
- Pointer update: on each new grant to entry k, pointer <= (k+1) mod ENTRIES.
- BUSY hold:
  - Grant is held regardless of i_request; deasserting the granted request mid-packet does not release it.
  - Requests from other entries are ignored until release.
- Release: in BUSY with i_free=1 the current packet is finished.
  - If some other or the same entry requests in that cycle, re-arbitrate with the updated pointer. The new grant appears the next cycle (back-to-back, no idle bubble) and the state stays BUSY.
  - If i_request=0, go to IDLE next cycle.
- Single-flit packets: i_free may assert in the first grant cycle and is honoured.
- i_free while IDLE: ignored.
- ENTRIES=1: always grant entry 0 when requested; pointer stays 0.
- Reset mid-packet: grant drops immediately (asynchronous). Packet integrity across reset is the system's responsibility.
- Invariant: o_grant is never multi-hot.
- Invariant: o_grant changes only on a cycle following i_free=1 or from IDLE.

Optional Feature:
- Macro: TNOC_FLIT_MUX_ARBITER_STATS_EN.
- Defined:
  - o_grant_count exists.
  - Counter i increments by 1 on each new grant to entry i and saturates at 2^COUNT_WIDTH-1 (no wrap).
  - Counters are cleared only by reset.
- Undefined: the port is absent and no counter flops exist.

Decomposition:
- Shared package tnoc_pkg: localparam for default COUNT_WIDTH, and enum tnoc_arb_state_e {TNOC_ARB_IDLE, TNOC_ARB_BUSY}.
- One natural sub-module, tnoc_round_robin_arbiter:
  - Combinational pointer-based first-one search over a rotated request vector.
  - Returns one-hot grant and the next pointer.
  - Reusable by virtual-channel allocators.

Test Plan:
- ENTRIES=4; i_request=4'b0100 from IDLE -> o_grant=4'b0100 one cycle later, o_busy=1; i_free next cycle with no requests -> o_grant=0 the following cycle.
- i_request=4'b1111 held; i_free pulsed every cycle -> grants 0001,0010,0100,1000,0001 on consecutive cycles, no idle gaps.
- Grant entry 1 as a 5-flit packet; drop i_request[1] and raise i_request[3] mid-packet -> o_grant stays 0010 until i_free, then 1000.
- i_free=1 while IDLE with i_request=0 -> no grant, pointer unchanged (next request 0001 granted first).
- Assert i_rst_n=0 while o_grant=0100 mid-packet -> o_grant=0 and o_busy=0 immediately; after release, request 1111 -> grant 0001.
- With TNOC_FLIT_MUX_ARBITER_STATS_EN defined and COUNT_WIDTH=2: grant entry 0 five times -> o_grant_count[0] reads 3 (saturated), others 0.
